// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 frame controller and its event queue.
//   ps2_state_t         frame FSM state encoding (IDLE, DATA, PARITY, STOP)
//   CODE_EXT / CODE_BRK prefix scan codes (extended key / key release)
//   TIMEOUT_CYC_DEFAULT default clk cycles allowed between kbclk falling edges
//   EVENT_W             width of one queued event {ext, brk, code[7:0]}
//   parity_ok()         odd-parity check over 8 data bits plus the parity bit
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] CODE_EXT            = 8'hE0;
  localparam logic [7:0] CODE_BRK            = 8'hF0;
  localparam int         TIMEOUT_CYC_DEFAULT = 5000;
  localparam int         EVENT_W             = 10;

  // PS/2 uses odd parity: the ones over data plus parity must be odd.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: small event queue with valid/ready pop.
//   clk, rst_n  clock, async active-low reset
//   push        write push_data this cycle (dropped if full and no pop)
//   push_data   event to enqueue
//   pop_valid   queue is non-empty; pop_data holds the head
//   pop_ready   consumer takes the head when pop_valid is high
//   pop_data    head entry
//   overflow    sticky: an event was dropped because the queue was full
// DEPTH must be a power of two (pointers wrap naturally).
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = EVENT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign full      = (count == (PW+1)'(DEPTH));
  assign pop       = pop_valid && pop_ready;
  // A same-cycle pop frees a slot, so a push into a full queue is still taken.
  assign wr_en     = push && (!full || pop);
  assign pop_valid = (count != '0);
  assign pop_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ps2_frame_ctrl.sv
// ps2_frame_ctrl: PS/2 keyboard frame receiver with prefix decode and event queue.
//   clk, rst_n   system clock, async active-low reset
//   kbclk/kbdata raw PS/2 lines (asynchronous, synchronized here)
//   ev_valid/ev_ready  valid/ready handshake on the queued key events
//   ev_code/ev_ext/ev_break  head event: scan code, E0-prefixed, F0-prefixed
//   err_parity   one-cycle pulse: parity failure with a good stop bit
//   err_frame    one-cycle pulse: bad start bit, bad stop bit or timeout
//   overflow     sticky: an event was dropped because the queue was full
//   busy         frame FSM is not idle
module ps2_frame_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kbclk,
  input  logic       kbdata,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow,
  output logic       busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic             kbclk_meta, kbclk_sync, kbclk_prev;
  logic             kbdata_meta, kbdata_sync;
  logic             fall;
  ps2_state_t       state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             par_ok;
  logic [TO_W-1:0]  to_cnt;
  logic             to_expire;
  logic             ext_flag, brk_flag;
  logic             stop_fall, byte_ok, push;
  logic [EVENT_W-1:0] push_data;
  logic [EVENT_W-1:0] head;

  // Synchronizers preset to 1 (idle bus) so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbclk_meta  <= 1'b1;
      kbclk_sync  <= 1'b1;
      kbclk_prev  <= 1'b1;
      kbdata_meta <= 1'b1;
      kbdata_sync <= 1'b1;
    end else begin
      kbclk_meta  <= kbclk;
      kbclk_sync  <= kbclk_meta;
      kbclk_prev  <= kbclk_sync;
      kbdata_meta <= kbdata;
      kbdata_sync <= kbdata_meta;
    end
  end

  assign fall      = kbclk_prev && !kbclk_sync;
  assign to_expire = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // The push is decided in the STOP edge cycle; the queue registers it, giving
  // ev_valid one cycle later. Prefix bytes only set flags and are never queued.
  assign stop_fall = (state == ST_STOP) && fall;
  assign byte_ok   = stop_fall && kbdata_sync && par_ok;
  assign push      = byte_ok && (shreg != CODE_EXT) && (shreg != CODE_BRK);
  assign push_data = {ext_flag, brk_flag, shreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_ok     <= 1'b0;
      to_cnt     <= '0;
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      err_parity <= 1'b0;
      err_frame  <= 1'b0;

      if (state == ST_IDLE || fall) to_cnt <= '0;
      else                          to_cnt <= to_cnt + TO_W'(1);

      if (state != ST_IDLE && !fall && to_expire) begin
        // Keyboard stalled mid-frame: drop the partial byte.
        state     <= ST_IDLE;
        busy      <= 1'b0;
        err_frame <= 1'b1;
        ext_flag  <= 1'b0;
        brk_flag  <= 1'b0;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!kbdata_sync) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end else begin
              err_frame <= 1'b1;
              ext_flag  <= 1'b0;
              brk_flag  <= 1'b0;
            end
          end
          ST_DATA: begin
            shreg   <= {kbdata_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_ok <= parity_ok(shreg, kbdata_sync);
            state  <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (!kbdata_sync) begin
              err_frame <= 1'b1;
              ext_flag  <= 1'b0;
              brk_flag  <= 1'b0;
            end else if (!par_ok) begin
              err_parity <= 1'b1;
              ext_flag   <= 1'b0;
              brk_flag   <= 1'b0;
            end else if (shreg == CODE_EXT) begin
              ext_flag <= 1'b1;
            end else if (shreg == CODE_BRK) begin
              brk_flag <= 1'b1;
            end else begin
              ext_flag <= 1'b0;
              brk_flag <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop_valid (ev_valid),
    .pop_ready (ev_ready),
    .pop_data  (head),
    .overflow  (overflow)
  );

  assign ev_ext   = head[9];
  assign ev_break = head[8];
  assign ev_code  = head[7:0];

endmodule

// File: tb/tb_ps2_frame_ctrl.sv
// tb_ps2_frame_ctrl: scoreboard bench for ps2_frame_ctrl.
// Frames are bit-banged onto kbclk/kbdata; a behavioural model decides, per
// frame, which event (if any) or error it must produce and queues the
// expectation. A monitor pops expectations as the DUT hands out events.
module tb_ps2_frame_ctrl;

  localparam int TO_CYC = 200;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kbclk = 1'b1;
  logic       kbdata = 1'b1;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext, ev_break, err_parity, err_frame, overflow, busy;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [9:0] expQ[$];
  bit         mExt = 1'b0, mBrk = 1'b0;
  bit         expOverflow = 1'b0;
  int         expParity = 0, expFrame = 0;
  int         gotParity = 0, gotFrame = 0;

  // 0: hold low, 1: hold high, 2: random
  int         readyMode = 0;

  ps2_frame_ctrl #(.TIMEOUT_CYC(TO_CYC), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kbclk      (kbclk),
    .kbdata     (kbdata),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_break   (ev_break),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Model: any error pulse clears both prefix flags.
  task automatic modelError(input bit isParity);
    if (isParity) expParity++;
    else          expFrame++;
    mExt = 1'b0;
    mBrk = 1'b0;
  endtask

  // Model: an accepted byte is either a prefix or a queued event; the queue
  // holds DEPTH events while nobody drains it, anything more is lost.
  task automatic modelAccept(input logic [7:0] b);
    if (b == 8'hE0)      mExt = 1'b1;
    else if (b == 8'hF0) mBrk = 1'b1;
    else begin
      if (expQ.size() >= DEPTH) expOverflow = 1'b1;
      else                      expQ.push_back({mExt, mBrk, b});
      mExt = 1'b0;
      mBrk = 1'b0;
    end
  endtask

  task automatic driveBits(input logic [10:0] bits, input int nBits);
    for (int i = 0; i < nBits; i++) begin
      kbdata = bits[i];
      waitCycles(4);
      kbclk = 1'b0;
      waitCycles(8);
      kbclk = 1'b1;
      waitCycles(4);
    end
    kbdata = 1'b1;
    waitCycles(6);
  endtask

  // One frame: start, 8 data bits LSB first, odd parity, stop. nBits < 11
  // truncates the frame, which must end in a timeout.
  task automatic applyStimulus(input logic [7:0] data, input bit badParity,
                               input bit badStop, input bit badStart, input int nBits);
    logic [10:0] bits;
    bits[0]   = badStart;
    bits[8:1] = data;
    bits[9]   = (~^data) ^ badParity;
    bits[10]  = ~badStop;
    if (badStart || nBits < 11) modelError(1'b0);
    else if (badStop)           modelError(1'b0);
    else if (badParity)         modelError(1'b1);
    else                        modelAccept(data);
    driveBits(bits, nBits);
    if (!badStart && nBits < 11) waitCycles(TO_CYC + 1);
  endtask

  task automatic checkCounts(input string tag);
    waitCycles(4);
    checkOutput({tag, "_err_parity_count"}, gotParity, expParity);
    checkOutput({tag, "_err_frame_count"}, gotFrame, expFrame);
    checkOutput({tag, "_overflow"}, {31'd0, overflow}, {31'd0, expOverflow});
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 400) begin
      waitCycles(1);
      n++;
    end
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL %s_drain: %0d events still expected, expected 0", tag, expQ.size());
      expQ.delete();
    end
    waitCycles(3);
    checkOutput({tag, "_ev_valid_after_drain"}, {31'd0, ev_valid}, 32'd0);
  endtask

  // Consumer: ready changes just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       ev_ready = 1'b0;
        1:       ev_ready = 1'b1;
        default: ev_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Monitor: samples on the falling edge, pops expectations on every
  // handshake, checks head stability under backpressure and pulse widths.
  logic [9:0] holdData;
  bit         holdValid = 1'b0;
  bit         prevParity = 1'b0, prevFrame = 1'b0;

  always @(negedge clk) begin
    logic [9:0] cur;
    logic [9:0] exp;
    if (!rst_n) begin
      holdValid  = 1'b0;
      prevParity = 1'b0;
      prevFrame  = 1'b0;
    end else begin
      cur = {ev_ext, ev_break, ev_code};
      if (holdValid && ev_valid) begin
        tests++;
        if (cur !== holdData) begin
          fails++;
          $display("[TB] FAIL head_stable: got 0x%0h, expected 0x%0h", cur, holdData);
        end
      end
      if (ev_valid && ev_ready) begin
        tests++;
        if (expQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_event: got {ext,brk,code}=0x%0h, expected none", cur);
        end else begin
          exp = expQ.pop_front();
          if (cur !== exp) begin
            fails++;
            $display("[TB] FAIL event: got {ext,brk,code}=0x%0h, expected 0x%0h", cur, exp);
          end
        end
      end
      holdValid = ev_valid && !ev_ready;
      holdData  = cur;
      if (prevParity) begin
        tests++;
        if (err_parity) begin
          fails++;
          $display("[TB] FAIL err_parity_width: got 1 in second cycle, expected 0");
        end
      end
      if (prevFrame) begin
        tests++;
        if (err_frame) begin
          fails++;
          $display("[TB] FAIL err_frame_width: got 1 in second cycle, expected 0");
        end
      end
      if (err_parity) gotParity++;
      if (err_frame)  gotFrame++;
      prevParity = err_parity;
      prevFrame  = err_frame;
    end
  end

  initial begin
    logic [7:0] b;
    logic [7:0] stallCodes [5];
    stallCodes[0] = 8'h16; stallCodes[1] = 8'h1E; stallCodes[2] = 8'h26;
    stallCodes[3] = 8'h25; stallCodes[4] = 8'h2E;

    // Reset state
    rst_n = 1'b0;
    waitCycles(3);
    checkOutput("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
    checkOutput("rst_ev_code", {24'd0, ev_code}, 32'd0);
    checkOutput("rst_ev_ext", {31'd0, ev_ext}, 32'd0);
    checkOutput("rst_ev_break", {31'd0, ev_break}, 32'd0);
    checkOutput("rst_err_parity", {31'd0, err_parity}, 32'd0);
    checkOutput("rst_err_frame", {31'd0, err_frame}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    waitCycles(5);

    // Directed decode cases with an always-ready consumer
    readyMode = 1;
    applyStimulus(8'h1C, 0, 0, 0, 11);
    applyStimulus(8'hF0, 0, 0, 0, 11);
    applyStimulus(8'h1C, 0, 0, 0, 11);
    applyStimulus(8'hE0, 0, 0, 0, 11);
    applyStimulus(8'hF0, 0, 0, 0, 11);
    applyStimulus(8'h75, 0, 0, 0, 11);
    applyStimulus(8'h1C, 1, 0, 0, 11);
    applyStimulus(8'h1C, 0, 0, 0, 11);
    waitDrain("directed");
    checkCounts("directed");

    // Truncated frame ends in a timeout, then a clean frame
    applyStimulus(8'h5A, 0, 0, 0, 5);
    checkOutput("timeout_busy", {31'd0, busy}, 32'd0);
    checkOutput("timeout_err_frame_count", gotFrame, expFrame);
    applyStimulus(8'h29, 0, 0, 0, 11);

    // Prefix discarded by a bad start bit, and a bad stop bit
    applyStimulus(8'hE0, 0, 0, 0, 11);
    applyStimulus(8'h00, 0, 0, 1, 1);
    applyStimulus(8'h1C, 0, 0, 0, 11);
    applyStimulus(8'hF0, 0, 0, 0, 11);
    applyStimulus(8'h1C, 0, 1, 0, 11);
    applyStimulus(8'h1C, 1, 1, 0, 11);
    applyStimulus(8'h4D, 0, 0, 0, 11);
    waitDrain("errors");
    checkCounts("errors");

    // Stalled consumer: fifth event is lost
    readyMode = 0;
    for (int i = 0; i < 5; i++) applyStimulus(stallCodes[i], 0, 0, 0, 11);
    checkCounts("stall");
    checkOutput("stall_ev_valid", {31'd0, ev_valid}, 32'd1);
    readyMode = 1;
    waitDrain("stall");

    // Random frames against a randomly stalling consumer
    readyMode = 2;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      applyStimulus(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0), 0, 11);
    end
    readyMode = 1;
    waitDrain("random");
    checkCounts("random");

    // Reset in the middle of a frame: no event, no error, flags cleared
    applyStimulus(8'hE0, 0, 0, 0, 11);
    kbdata = 1'b0;
    waitCycles(4);
    kbclk = 1'b0;
    waitCycles(8);
    kbclk = 1'b1;
    kbdata = 1'b1;
    waitCycles(20);
    rst_n = 1'b0;
    mExt = 1'b0;
    mBrk = 1'b0;
    expOverflow = 1'b0;
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(5);
    checkOutput("midreset_ev_valid", {31'd0, ev_valid}, 32'd0);
    checkCounts("midreset");
    applyStimulus(8'h1C, 0, 0, 0, 11);
    waitDrain("midreset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_frame_ctrl.md
PS2_FRAME_CTRL -- requirements
Module: ps2_frame_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 5000: clk cycles without a kbclk falling edge before an in-progress frame is aborted.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: event queue entries, a power of two.
REQ-003 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port kbclk  in  1  raw PS/2 clock, asynchronous to clk.
REQ-006 SHALL have port kbdata  in  1  raw PS/2 data, asynchronous to clk.
REQ-007 SHALL have port ev_valid  out  1  queue head holds a key event.
REQ-008 SHALL have port ev_ready  in  1  consumer accepts the head event.
REQ-009 SHALL have port ev_code  out  8  scan code of the head event.
REQ-010 SHALL have port ev_ext  out  1  head event was preceded by E0.
REQ-011 SHALL have port ev_break  out  1  head event was preceded by F0 (key release).
REQ-012 SHALL have port err_parity  out  1  one-cycle pulse on a parity failure.
REQ-013 SHALL have port err_frame  out  1  one-cycle pulse on a bad start bit, bad stop bit or timeout.
REQ-014 SHALL have port overflow  out  1  sticky; an event was dropped because the queue was full.
REQ-015 SHALL have port busy  out  1  high while the frame FSM is not in IDLE.

Function
REQ-016 SHALL pass kbclk and kbdata through two-flop synchronizers each; a falling edge is synced prev=1, cur=0.
REQ-017 SHALL sample synced kbdata only in the cycle a kbclk falling edge is detected.
REQ-018 SHALL implement FSM states IDLE, DATA, PARITY and STOP.
REQ-019 On a falling edge in IDLE, data 0 SHALL go to DATA with bit_cnt=0; data 1 SHALL stay in IDLE and pulse err_frame.
REQ-020 In DATA, each falling edge SHALL shift one bit into the byte, LSB first; after the 8th bit the FSM goes to PARITY.
REQ-021 In PARITY, a falling edge SHALL record the parity check: pass when the count of ones over 8 data bits plus the parity bit is odd. The FSM then goes to STOP.
REQ-022 In STOP, a falling edge SHALL return the FSM to IDLE. Stop=1 with parity pass accepts the byte. Stop=0 pulses err_frame. Parity fail with stop=1 pulses err_parity. Both failing pulses err_frame only. A rejected byte is discarded.
REQ-023 In any non-IDLE state, TIMEOUT_CYC consecutive cycles without a falling edge SHALL return the FSM to IDLE, discard the byte and pulse err_frame.
REQ-024 The timeout counter SHALL clear on every falling edge and whenever the FSM is in IDLE.
REQ-025 Accepted byte 0xE0 SHALL set ext_flag; 0xF0 SHALL set brk_flag; neither is queued.
REQ-026 Any other accepted byte SHALL push {ext_flag, brk_flag, byte} and clear both flags in the same cycle.
REQ-027 Any err_parity or err_frame pulse SHALL clear ext_flag and brk_flag.
REQ-028 A push SHALL be visible on ev_valid in the cycle after the STOP falling-edge detection cycle (1-cycle latency).
REQ-029 A pop SHALL occur when ev_valid && ev_ready; the head event is stable while ev_valid && !ev_ready.
REQ-030 A push while full with no pop SHALL drop the event and set overflow; a push while full with a same-cycle pop SHALL be accepted.
REQ-031 A push while empty SHALL make the new entry the head; no bypass in the same cycle.
REQ-032 Events SHALL leave the queue in arrival order; read and write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-033 On rst_n low the block SHALL set: FSM IDLE; bit_cnt, timeout counter and flags 0; queue empty; ev_valid, err_parity, err_frame, overflow and busy 0; ev_code 0x00; ev_ext and ev_break 0.
REQ-034 On rst_n low the synchronizer flops SHALL be set to 1 (idle bus) so no edge is seen at reset release.
REQ-035 Reset mid-frame SHALL abort the frame with no event and no error pulse.

Structure
REQ-036 Shared package ps2_pkg SHALL hold the FSM state encoding, constants CODE_EXT=8'hE0 and CODE_BRK=8'hF0, and the default TIMEOUT_CYC.
REQ-037 The event queue SHALL be sub-module ps2_event_fifo (10-bit wide, FIFO_DEPTH deep, valid/ready pop); the FSM, synchronizers and prefix decode stay in ps2_frame_ctrl.

Verification
REQ-038 Frame 0x1C with parity 0 and stop 1 -> exactly one event: code 0x1C, ext 0, break 0.
REQ-039 Frames F0, 1C -> one event: code 0x1C, break 1, ext 0.
REQ-040 Frames E0, F0, 75 -> one event: code 0x75, ext 1, break 1.
REQ-041 Frame 0x1C with parity 1 -> err_parity pulses for one cycle, no event; a following 0x1C frame gives ext 0, break 0.
REQ-042 Frame stopped after 4 data bits, then TIMEOUT_CYC+1 idle cycles -> one err_frame pulse, busy=0; a following 0x29 frame decodes correctly.
REQ-043 Five make frames 0x16, 0x1E, 0x26, 0x25, 0x2E with ev_ready=0 -> overflow=1; draining returns 0x16, 0x1E, 0x26, 0x25 in order, then ev_valid=0.
